// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, 11-bit frame, device ack.
// Optional per-transfer watchdog is compiled in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_low,
  output logic       ps2_dat_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int CW = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [7:0]    byte_q, byte_n;
  logic          par_q, par_n;
  logic [2:0]    idx_q, idx_n, idx_inc;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          clk_low_q, clk_low_n;
  logic          dat_low_q, dat_low_n;
  logic          done_q, done_n;
  logic          err_q, err_n;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_n;
`else
  if (TIMEOUT_CYCLES < 0) begin : g_no_watchdog
  end
`endif

  assign fall    = clk_prev & ~clk_s2;
  assign idx_inc = idx_q + 3'd1;

  always_comb begin
    state_n   = state;
    byte_n    = byte_q;
    par_n     = par_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q;
    clk_low_n = clk_low_q;
    dat_low_n = dat_low_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        if (tx_valid) begin
          byte_n    = tx_data;
          par_n     = ~^tx_data;
          cnt_n     = CW'(INHIBIT_CYCLES);
          clk_low_n = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q <= CW'(1)) begin
          cnt_n     = '0;
          clk_low_n = 1'b0;
          dat_low_n = 1'b1;
          state_n   = RTS;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      RTS: begin
        if (fall) begin
          idx_n     = '0;
          dat_low_n = ~byte_q[0];
          state_n   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          if (idx_q == 3'd7) begin
            dat_low_n = ~par_q;
            state_n   = PARITY;
          end else begin
            idx_n     = idx_inc;
            dat_low_n = ~byte_q[idx_inc];
          end
        end
      end
      PARITY: begin
        if (fall) begin
          dat_low_n = 1'b0;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (!dat_s2) begin
            state_n = ACK;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      // The synced clock is still low right after the ack edge, so this extra cycle never delays tx_done.
      ACK: state_n = WAIT_IDLE;
      WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_n = wd_q;
    if (state == INHIBIT && state_n == RTS) begin
      wd_n = WW'(1);
    end else if ((state inside {RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE}) &&
                 !(state == WAIT_IDLE && state_n == IDLE)) begin
      if (wd_q >= WW'(TIMEOUT_CYCLES)) begin
        state_n   = IDLE;
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        err_n     = 1'b1;
        wd_n      = '0;
      end else begin
        wd_n = wd_q + WW'(1);
      end
    end else if (state_n == IDLE) begin
      wd_n = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      byte_q    <= '0;
      par_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state     <= state_n;
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      clk_prev  <= clk_s2;
      dat_s1    <= ps2_dat;
      dat_s2    <= dat_s1;
      byte_q    <= byte_n;
      par_q     <= par_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      clk_low_q <= clk_low_n;
      dat_low_q <= dat_low_n;
      done_q    <= done_n;
      err_q     <= err_n;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= wd_n;
`endif
    end
  end

  assign ps2_clk_low = clk_low_q;
  assign ps2_dat_low = dat_low_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND PS/2 bus with a device model, frame-level reference model
// checked every cycle, plus directed transfers with hand-computed frames.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_low, ps2_dat_low, tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_line, ps2_dat_line;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned n_done = 0, n_err = 0, n_clk_low = 0;

  assign ps2_clk_line = dev_clk & ~ps2_clk_low;
  assign ps2_dat_line = dev_dat & ~ps2_dat_low;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk_line), .ps2_dat(ps2_dat_line),
    .ps2_clk_low(ps2_clk_low), .ps2_dat_low(ps2_dat_low),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error), .busy(busy)
  );

  // Reference model: phase 0 idle, 1 inhibit, 2 sending (m_k falls seen), 3 acked.
  int          m_phase = 0, m_inh = 0, m_k = 0, m_wd = 0, m_ph0 = 0;
  logic [10:0] m_frame = '0;
  logic        m_cs1 = 1'b1, m_cs2 = 1'b1, m_cprev = 1'b1, m_ds1 = 1'b1, m_ds2 = 1'b1;
  logic        m_fall = 1'b0;
  logic        e_clk_low = 1'b0, e_dat_low = 1'b0, e_done = 1'b0, e_err = 1'b0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    model_live = 1'b1;
    m_fall = m_cprev & ~m_cs2;
    m_ph0 = m_phase;
    e_done = 1'b0;
    e_err = 1'b0;
    if (!reset) begin
      m_phase = 0;
      e_clk_low = 1'b0;
      e_dat_low = 1'b0;
      m_cs1 = 1'b1; m_cs2 = 1'b1; m_cprev = 1'b1; m_ds1 = 1'b1; m_ds2 = 1'b1;
    end else begin
      case (m_phase)
        0: if (tx_valid) begin
          m_frame = {1'b1, ~^tx_data, tx_data, 1'b0};
          m_inh = INH;
          e_clk_low = 1'b1;
          m_phase = 1;
        end
        1: begin
          m_inh--;
          if (m_inh <= 0) begin
            e_clk_low = 1'b0;
            e_dat_low = ~m_frame[0];
            m_k = 0;
            m_wd = 0;
            m_phase = 2;
          end
        end
        2: if (m_fall) begin
          m_k++;
          if (m_k <= 10) e_dat_low = ~m_frame[m_k];
          else if (!m_ds2) m_phase = 3;
          else begin e_err = 1'b1; m_phase = 0; end
        end
        3: if (m_cs2 && m_ds2) begin e_done = 1'b1; m_phase = 0; end
        default: m_phase = 0;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (m_ph0 >= 2 && !e_done) begin
        m_wd++;
        if (m_wd == TMO) begin
          e_err = 1'b1; e_clk_low = 1'b0; e_dat_low = 1'b0; m_phase = 0;
        end
      end
`endif
      m_cprev = m_cs2; m_cs2 = m_cs1; m_cs1 = ps2_clk_line;
      m_ds2 = m_ds1; m_ds1 = ps2_dat_line;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      compared++;
      if ({ps2_clk_low, ps2_dat_low, tx_ready, busy, tx_done, tx_error} !==
          {e_clk_low, e_dat_low, (m_phase == 0), (m_phase != 0), e_done, e_err}) begin
        mismatched++;
        $display("FAIL cycle_model t=%0t got clk_low,dat_low,ready,busy,done,err=%b%b%b%b%b%b want %b%b%b%b%b%b",
                 $time, ps2_clk_low, ps2_dat_low, tx_ready, busy, tx_done, tx_error,
                 e_clk_low, e_dat_low, (m_phase == 0), (m_phase != 0), e_done, e_err);
      end
      if (tx_done) n_done++;
      if (tx_error) n_err++;
      if (ps2_clk_low) n_clk_low++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH + 40; i++) begin
      @(negedge clk);
      if (!ps2_clk_low && ps2_dat_low) begin ok = 1'b1; break; end
    end
  endtask

  task automatic device_frame(input int nfalls, input bit ack, input int inject, output logic [10:0] smp);
    bit ok;
    smp = '0;
    wait_rts(ok);
    check("rts_reached", {31'd0, ok}, 32'd1);
    if (!ok) return;
    cyc(H);
    smp[0] = ps2_dat_line;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      if (i <= 10) smp[i] = ps2_dat_line;
      if (i == 10 && ack) dev_dat = 1'b0;
      if (i == inject) begin
        tx_data = 8'hFF; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0; cyc(H - 1);
      end else begin
        cyc(H);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic transfer(input string name, input logic [7:0] b, input bit ack, input int inject,
                          input logic [10:0] exp_frame, input int exp_done, input int exp_err);
    int unsigned d0, e0;
    logic [10:0] smp;
    d0 = n_done; e0 = n_err;
    tx_data = b; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0;
    device_frame(11, ack, inject, smp);
    cyc(12);
    check({name, "_frame"}, {21'd0, smp}, {21'd0, exp_frame});
    check({name, "_done_count"}, n_done - d0, exp_done);
    check({name, "_err_count"}, n_err - e0, exp_err);
    check({name, "_idle_lines"}, {29'd0, busy, ps2_clk_low, ps2_dat_low}, 32'd0);
  endtask

  initial begin
    logic [10:0] smp;
    int unsigned c0, d0, e0;
    bit ok;
    int got;
    #200_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] smp;
    int unsigned c0, d0, e0;
    bit ok;
    int got;
    cyc(3);
    check("reset_outputs", {26'd0, ps2_clk_low, ps2_dat_low, tx_ready, busy, tx_done, tx_error}, 32'b001000);
    reset = 1'b1;
    cyc(3);

    transfer("ed", 8'hED, 1'b1, 0, 11'h7DA, 1, 0);

    c0 = n_clk_low;
    transfer("01", 8'h01, 1'b1, 0, 11'h402, 1, 0);
    check("inhibit_len", n_clk_low - c0, INH);

    transfer("nack", 8'hA5, 1'b0, 0, 11'h74A, 0, 1);

    // Reset after bit 3 (bit 3 of 0x96 is 0, so data is being pulled low).
    d0 = n_done; e0 = n_err;
    tx_data = 8'h96; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0;
    device_frame(4, 1'b0, 0, smp);
    check("mid_frame_bits", {27'd0, smp[4:0]}, 32'h0C);
    check("mid_dat_low", {31'd0, ps2_dat_low}, 32'd1);
    reset = 1'b0;
    cyc(1);
    check("reset_release", {29'd0, ps2_clk_low, ps2_dat_low, busy}, 32'd0);
    reset = 1'b1;
    cyc(30);
    check("reset_no_pulses", (n_done - d0) + (n_err - e0), 32'd0);
    transfer("f4", 8'hF4, 1'b1, 0, 11'h5E8, 1, 0);

    transfer("inject", 8'h3C, 1'b1, 5, 11'h678, 1, 0);
    cyc(INH + 10);
    check("inject_not_queued", {31'd0, busy}, 32'd0);

    // Device never clocks.
    e0 = n_err;
    tx_data = 8'h55; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0;
    wait_rts(ok);
    check("nc_rts_reached", {31'd0, ok}, 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
    got = -1;
    for (int i = 1; i <= TMO + 50; i++) begin
      @(negedge clk);
      if (tx_error) begin got = i; break; end
    end
    check("timeout_latency", got, TMO);
    #1;
    cyc(2);
    check("timeout_released", {29'd0, ps2_clk_low, ps2_dat_low, busy}, 32'd0);
`else
    cyc(3000);
    check("no_clock_stays_rts", {28'd0, busy, ps2_clk_low, ps2_dat_low, tx_error}, 32'b1010);
    check("no_clock_no_error", n_err - e0, 32'd0);
    reset = 1'b0; cyc(2); reset = 1'b1; cyc(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
